// File: rtl/cra_pkg.sv
// Shared definitions for the control-RAM address sequencer: default widths,
// the microaddress type and the next-address op encoding.
package cra_pkg;

  localparam int CRA_ADR_W       = 11;
  localparam int CRA_DISP_W      = 4;
  localparam int CRA_STACK_DEPTH = 16;
  localparam int CRA_SP_W        = $clog2(CRA_STACK_DEPTH) + 1;

  typedef logic [CRA_ADR_W-1:0] cra_adr_t;

  // Codes 5-7 are reserved and behave as JUMP
  typedef enum logic [2:0] {
    OP_JUMP     = 3'd0,
    OP_CALL     = 3'd1,
    OP_RETURN   = 3'd2,
    OP_DISPATCH = 3'd3,
    OP_SKIP     = 3'd4
  } cra_op_e;

endpackage

// File: rtl/cra_adr_seq_if.sv
// Microword, diagnostic and status signals between the CRA control logic
// (master) and the address sequencer (slave).
interface cra_adr_seq_if
  import cra_pkg::*;
#(
  parameter int ADR_W  = CRA_ADR_W,
  parameter int DISP_W = CRA_DISP_W,
  parameter int SP_W   = CRA_SP_W
) ();

  logic [ADR_W-1:0]  cra_j_h;
  logic [2:0]        cra_op_h;
  logic [DISP_W-1:0] cra_disp_h;
  logic              cra_skip_cond_h;
  logic              cra_stall_h;
  logic              diag_adr_load_l;
  logic [ADR_W-1:0]  diag_adr_h;
  logic              diag_clr_err_l;
  logic [ADR_W-1:0]  cra_adr_h;
  logic [SP_W-1:0]   cra_sp_h;
  logic              cra_stack_ovf_h;
  logic              cra_stack_unf_h;

  modport master (
    output cra_j_h, cra_op_h, cra_disp_h, cra_skip_cond_h, cra_stall_h,
    output diag_adr_load_l, diag_adr_h, diag_clr_err_l,
    input  cra_adr_h, cra_sp_h, cra_stack_ovf_h, cra_stack_unf_h
  );

  modport slave (
    input  cra_j_h, cra_op_h, cra_disp_h, cra_skip_cond_h, cra_stall_h,
    input  diag_adr_load_l, diag_adr_h, diag_clr_err_l,
    output cra_adr_h, cra_sp_h, cra_stack_ovf_h, cra_stack_unf_h
  );

endinterface

// File: rtl/cra_ret_stack.sv
// Subroutine return-address LIFO. Push/pop are ignored when full/empty;
// only the top entry is readable and it is read combinationally.
module cra_ret_stack
  import cra_pkg::*;
#(
  parameter int ADR_W = CRA_ADR_W,
  parameter int DEPTH = CRA_STACK_DEPTH,
  parameter int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [ADR_W-1:0] push_data,
  output logic [ADR_W-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [SP_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADR_W-1:0] mem_r [DEPTH];
  logic [SP_W-1:0]  count_r;
  logic [PTR_W-1:0] wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_s;
  logic             do_push_s;
  logic             do_pop_s;

  // The low count bits address the next free slot; the entry below it is the top
  assign wr_ptr_s  = count_r[PTR_W-1:0];
  assign rd_ptr_s  = wr_ptr_s - PTR_W'(1);
  assign full      = (count_r == SP_W'(DEPTH));
  assign empty     = (count_r == SP_W'(0));
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign top_data  = mem_r[rd_ptr_s];
  assign count     = count_r;

  // Occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= SP_W'(0);
    end else if (do_push_s) begin
      count_r <= count_r + SP_W'(1);
    end else if (do_pop_s) begin
      count_r <= count_r - SP_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_s] <= push_data;
    end
  end

endmodule

// File: rtl/cra_adr_seq.sv
// Control-RAM address sequencer: registers the microaddress driving the CRAM
// and computes the next one from the current microword and the return stack.
module cra_adr_seq
  import cra_pkg::*;
#(
  parameter int ADR_W       = CRA_ADR_W,
  parameter int STACK_DEPTH = CRA_STACK_DEPTH,
  parameter int DISP_W      = CRA_DISP_W
) (
  input  logic               clk_cra_00_h,
  input  logic               mr_reset_01_l,
  cra_adr_seq_if.slave       bus
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADR_W-1:0] cra_adr_r;
  logic             ovf_r;
  logic             unf_r;
  logic [ADR_W-1:0] adr_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic [ADR_W-1:0] ret_adr_s;
  logic [ADR_W-1:0] top_s;
  logic             full_s;
  logic             empty_s;
  logic [SP_W-1:0]  sp_s;
  cra_op_e          op_s;

  assign op_s      = cra_op_e'(bus.cra_op_h);
  // Return address wraps naturally at the top of the microaddress space
  assign ret_adr_s = cra_adr_r + ADR_W'(1);

  cra_ret_stack #(
    .ADR_W (ADR_W),
    .DEPTH (STACK_DEPTH),
    .SP_W  (SP_W)
  ) u_ret_stack (
    .clk       (clk_cra_00_h),
    .rst_n     (mr_reset_01_l),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (ret_adr_s),
    .top_data  (top_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (sp_s)
  );

  // Next-address, stack control and error-flag selection
  always_comb begin
    adr_nxt_s = cra_adr_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;

    // A clear is applied first so that an error on the same edge re-sets the flag
    if (!bus.diag_clr_err_l) begin
      ovf_nxt_s = 1'b0;
      unf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
      unf_nxt_s = unf_r;
    end

    if (!bus.diag_adr_load_l) begin
      adr_nxt_s = bus.diag_adr_h;
    end else if (bus.cra_stall_h) begin
      adr_nxt_s = cra_adr_r;
    end else begin
      case (op_s)
        OP_CALL: begin
          adr_nxt_s = bus.cra_j_h;
          if (full_s) begin
            ovf_nxt_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end
        OP_RETURN: begin
          if (empty_s) begin
            adr_nxt_s = {ADR_W{1'b0}};
            unf_nxt_s = 1'b1;
          end else begin
            adr_nxt_s = top_s;
            pop_s     = 1'b1;
          end
        end
        OP_DISPATCH: adr_nxt_s = bus.cra_j_h | {{(ADR_W-DISP_W){1'b0}}, bus.cra_disp_h};
        OP_SKIP:     adr_nxt_s = bus.cra_j_h | {{(ADR_W-1){1'b0}}, bus.cra_skip_cond_h};
        default:     adr_nxt_s = bus.cra_j_h;
      endcase
    end
  end

  // Microaddress and sticky error flag registers
  always_ff @(posedge clk_cra_00_h or negedge mr_reset_01_l) begin
    if (!mr_reset_01_l) begin
      cra_adr_r <= {ADR_W{1'b0}};
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      cra_adr_r <= adr_nxt_s;
      ovf_r     <= ovf_nxt_s;
      unf_r     <= unf_nxt_s;
    end
  end

  assign bus.cra_adr_h       = cra_adr_r;
  assign bus.cra_sp_h        = sp_s;
  assign bus.cra_stack_ovf_h = ovf_r;
  assign bus.cra_stack_unf_h = unf_r;

endmodule

// File: doc/cra_adr_seq.md
Name: cra_adr_seq

Overview:
- Control-RAM address sequencer: the stage directly upstream of the CRAM slices.
- Registers the 11-bit microinstruction address that drives the CRAM array each cycle.
- Computes the next address from the jump field and the op field of the current microword, plus dispatch bits, the skip condition and a 16-deep subroutine call/return stack.
- Provides a diagnostic address-load path and sticky stack error flags for the console.

Parameters:
- ADR_W, 11, microaddress width
- STACK_DEPTH, 16, number of subroutine return entries (power of two)
- DISP_W, 4, number of dispatch bits ORed into the low address bits

Ports:
- clk_cra_00_h  input  1  CRA clock; all state updates on the rising edge
- mr_reset_01_l  input  1  asynchronous active-low master reset
- cra_j_h  input  ADR_W  jump field of the current microword
- cra_op_h  input  3  next-address op: 0=JUMP, 1=CALL, 2=RETURN, 3=DISPATCH, 4=SKIP, 5-7 reserved
- cra_disp_h  input  DISP_W  dispatch bits
- cra_skip_cond_h  input  1  selected skip condition
- cra_stall_h  input  1  hold the current address (memory wait)
- diag_adr_load_l  input  1  diagnostic address load strobe, active low
- diag_adr_h  input  ADR_W  diagnostic address value
- diag_clr_err_l  input  1  clears the sticky error flags, active low
- cra_adr_h  output  ADR_W  registered microaddress to the CRAM
- cra_sp_h  output  5  stack occupancy, 0..STACK_DEPTH
- cra_stack_ovf_h  output  1  sticky: CALL issued with the stack full
- cra_stack_unf_h  output  1  sticky: RETURN issued with the stack empty

Behaviour:
- Reset (asynchronous, active low):
  - cra_adr_h = 0, stack pointer = 0, both error flags = 0.
  - Stack contents are don't-care.
  - Deassertion takes effect at the first following clock edge.
- Per-edge priority:
  1. diag_adr_load_l low: cra_adr_h <= diag_adr_h. Stack is untouched. This wins over stall and over any op.
  2. Otherwise, if cra_stall_h is high: all state is held, with no push or pop.
  3. Otherwise, apply the op below.
- Ops (latency is one clock; the new address is visible the cycle after the op is presented):
  - JUMP, and reserved 5-7: cra_adr_h <= cra_j_h.
  - CALL:
    - Stack not full: push (cra_adr_h + 1) mod 2^ADR_W, sp++, and cra_adr_h <= cra_j_h.
    - Stack full: no push, sp unchanged, ovf <= 1, and cra_adr_h <= cra_j_h.
  - RETURN:
    - Stack not empty: cra_adr_h <= top entry, sp--. cra_j_h is ignored.
    - Stack empty: cra_adr_h <= 0, unf <= 1, sp stays 0.
  - DISPATCH: cra_adr_h <= cra_j_h with cra_disp_h ORed into bits [DISP_W-1:0].
  - SKIP: cra_adr_h <= cra_j_h with cra_skip_cond_h ORed into bit 0.
- Address arithmetic: the return address wraps, so 0x7FF + 1 = 0x000.
- Error flags:
  - Sticky until reset or diag_clr_err_l is low at a clock edge.
  - If a clear and a new error occur on the same edge, the set wins.
- Stack implementation: a LIFO of STACK_DEPTH × ADR_W registers. Only the top entry is read, combinationally.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package cra_pkg holds:
  - the op enumeration (JUMP, CALL, RETURN, DISPATCH, SKIP),
  - the ADR_W and DISP_W defaults,
  - the microaddress typedef.
- One natural sub-module: cra_ret_stack, a synchronous LIFO with push/pop/full/empty and an occupancy count, instantiated once.

Test Plan:
- Reset, then JUMP with cra_j_h=0x123 -> cra_adr_h=0x123 one clock later; sp=0, flags 0.
- From address 0x7FF, CALL to 0x040 -> cra_adr_h=0x040, sp=1. Then RETURN -> cra_adr_h=0x000 (wrap), sp=0.
- 16 nested CALLs, then a 17th CALL to 0x200 -> cra_adr_h=0x200, sp=16, ovf=1. 16 RETURNs unwind in LIFO order. A further RETURN -> cra_adr_h=0, unf=1. Pulse diag_clr_err_l -> both flags 0.
- DISPATCH with j=0x3F0, disp=0xA -> 0x3FA. SKIP with j=0x100 and cond=1 -> 0x101; with cond=0 -> 0x100.
- cra_stall_h high with CALL presented for 3 cycles -> address and sp unchanged. With stall still high, diag_adr_load_l low and diag_adr_h=0x555 -> cra_adr_h=0x555, sp unchanged.
- Assert mr_reset_01_l low asynchronously mid-cycle with sp=5 and ovf=1 -> cra_adr_h=0, sp=0, and flags 0 immediately, before the next clock edge.
